alu_op_sequencer: RTL

- Parametrised hardware control sequencer for the mini CPU datapath.
- Accepts one register-transfer command per valid/ready handshake: immediate load, binary ALU op, unary ALU op, or wide (mul/div) op.
- Drives the datapath's one-hot register out/in strobes, MDR/Y/Z/HI/LO strobes and ALU op code for the required number of cycles, then pulses `done`.
- Sits between the future instruction decoder and `data_path`, replacing hand-written per-op bench sequencing.

---
 rtl/alu_op_sequencer_pkg.sv | 90 +++++++++
 rtl/alu_op_sequencer_if.sv | 29 ++
 rtl/alu_op_sequencer_onehot_dec.sv | 21 ++
 rtl/alu_op_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared CPU definitions: ALU op codes, command types, sequencer states and
// the per-state datapath strobe pattern.
package cpu_pkg;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_SHR = 5'b00100;
    localparam logic [4:0] OP_SHL = 5'b00101;
    localparam logic [4:0] OP_ROL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_MUL = 5'b01000;
    localparam logic [4:0] OP_DIV = 5'b01001;
    localparam logic [4:0] OP_NEG = 5'b01010;
    localparam logic [4:0] OP_NOT = 5'b01011;

    typedef enum logic [1:0] {
        CMD_LOAD = 2'd0,
        CMD_ALU2 = 2'd1,
        CMD_ALU1 = 2'd2,
        CMD_WIDE = 2'd3
    } cmd_type_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_S4   = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    typedef struct packed {
        logic loin;
        logic hiin;
        logic zhighout;
        logic zlowout;
        logic zhighin;
        logic zlowin;
        logic yin;
        logic mdrout;
        logic mdrin;
        logic read;
    } strobes_t;

    // Scalar strobes for a given state of a given command; register strobes are decoded separately.
    function automatic strobes_t strobes_for(input state_e st, input cmd_type_e ty);
        strobes_t s;
        s = '0;
        case (st)
            ST_S1: begin
                if (ty == CMD_LOAD) begin
                    s.read  = 1'b1;
                    s.mdrin = 1'b1;
                end else if (ty == CMD_ALU1) begin
                    s.zlowin  = 1'b1;
                    s.zhighin = 1'b1;
                end else begin
                    s.yin = 1'b1;
                end
            end
            ST_S2: begin
                if (ty == CMD_LOAD) begin
                    s.mdrout = 1'b1;
                end else if (ty == CMD_ALU1) begin
                    s.zlowout = 1'b1;
                end else begin
                    s.zlowin  = 1'b1;
                    s.zhighin = 1'b1;
                end
            end
            ST_S3: begin
                s.zlowout = 1'b1;
                if (ty == CMD_WIDE) begin
                    s.loin = 1'b1;
                end else begin
                    s.loin = 1'b0;
                end
            end
            ST_S4: begin
                s.zhighout = 1'b1;
                s.hiin     = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command handshake between the instruction decoder (master) and the
// ALU op sequencer (slave).
interface alu_op_sequencer_if
    import cpu_pkg::*;
#(
    parameter int NREG = 16,
    parameter int RW   = $clog2(NREG),
    parameter int OPW  = 5,
    parameter int DW   = 32
);
    logic            cmd_valid;
    logic            cmd_ready;
    cmd_type_e       cmd_type;
    logic [OPW-1:0]  cmd_op;
    logic [RW-1:0]   cmd_rd;
    logic [RW-1:0]   cmd_rs;
    logic [RW-1:0]   cmd_rt;
    logic [DW-1:0]   cmd_imm;

    modport master (
        output cmd_valid, cmd_type, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/alu_op_sequencer_onehot_dec.sv
// Register index to one-hot strobe vector; all zeros when not enabled.
module onehot_dec #(
    parameter int NREG = 16,
    parameter int RW   = $clog2(NREG)
) (
    input  logic [RW-1:0]   idx,
    input  logic            en,
    output logic [NREG-1:0] vec
);

    // Single-bit decode of idx, gated by en
    always_comb begin
        vec = '0;
        if (en) begin
            vec[idx] = 1'b1;
        end else begin
            vec = '0;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Control sequencer: turns one register-transfer command into the per-cycle
// strobe pattern for data_path, then pulses done.
module alu_op_sequencer
    import cpu_pkg::*;
#(
    parameter int NREG = 16,
    parameter int RW   = $clog2(NREG),
    parameter int OPW  = 5,
    parameter int DW   = 32
) (
    input  logic             Clock,
    input  logic             clear,
    alu_op_sequencer_if.slave cmd,
    output logic [DW-1:0]    Mdatain,
    output logic             Read,
    output logic             MDRin,
    output logic             MDRout,
    output logic             Yin,
    output logic             Zlowin,
    output logic             ZHighin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic [NREG-1:0]  Rout,
    output logic [NREG-1:0]  Rin,
    output logic [OPW-1:0]   op,
    output logic             busy,
    output logic             done
);

    state_e          state_q, state_d;
    cmd_type_e       type_q, type_d;
    logic [RW-1:0]   rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [DW-1:0]   mdatain_q, mdatain_d;
    strobes_t        strb_q, strb_d;
    logic [NREG-1:0] rout_q, rout_d, rin_q, rin_d;
    logic            busy_q, busy_d, done_q, done_d;

    logic            cmd_ready_s, accept_s;
    logic            rout_en_s, rin_en_s;
    logic [RW-1:0]   rout_idx_s;

    assign cmd_ready_s   = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept_s      = cmd.cmd_valid && cmd_ready_s;
    assign cmd.cmd_ready = cmd_ready_s;

    // Next state, command latch, and the strobes that go with the next state
    // so every output leaves a flop in the same cycle as its state.
    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        rd_d      = rd_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        op_d      = op_q;
        mdatain_d = mdatain_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_d = ST_S1;
                    type_d  = cmd.cmd_type;
                    rd_d    = cmd.cmd_rd;
                    rs_d    = cmd.cmd_rs;
                    rt_d    = cmd.cmd_rt;
                    op_d    = cmd.cmd_op;
                    if (cmd.cmd_type == CMD_LOAD) begin
                        mdatain_d = cmd.cmd_imm;
                    end else begin
                        mdatain_d = mdatain_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_S1: state_d = ST_S2;
            ST_S2: begin
                if ((type_q == CMD_LOAD) || (type_q == CMD_ALU1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_S3;
                end
            end
            ST_S3: begin
                if (type_q == CMD_WIDE) begin
                    state_d = ST_S4;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_S4:   state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase

        strb_d    = strobes_for(state_d, type_d);
        rout_en_s = ((state_d == ST_S1) && (type_d != CMD_LOAD)) ||
                    ((state_d == ST_S2) && ((type_d == CMD_ALU2) || (type_d == CMD_WIDE)));
        rin_en_s  = ((state_d == ST_S2) && ((type_d == CMD_LOAD) || (type_d == CMD_ALU1))) ||
                    ((state_d == ST_S3) && (type_d == CMD_ALU2));
        if (state_d == ST_S1) begin
            rout_idx_s = rs_d;
        end else begin
            rout_idx_s = rt_d;
        end
        busy_d = (state_d == ST_S1) || (state_d == ST_S2) ||
                 (state_d == ST_S3) || (state_d == ST_S4);
        done_d = (state_d == ST_DONE);
    end

    onehot_dec #(.NREG(NREG), .RW(RW)) u_rout_dec (
        .idx (rout_idx_s),
        .en  (rout_en_s),
        .vec (rout_d)
    );

    onehot_dec #(.NREG(NREG), .RW(RW)) u_rin_dec (
        .idx (rd_d),
        .en  (rin_en_s),
        .vec (rin_d)
    );

    // State and output registers; clear drops every strobe at once.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q   <= ST_IDLE;
            type_q    <= CMD_LOAD;
            rd_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            op_q      <= '0;
            mdatain_q <= '0;
            strb_q    <= '0;
            rout_q    <= '0;
            rin_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            rd_q      <= rd_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            op_q      <= op_d;
            mdatain_q <= mdatain_d;
            strb_q    <= strb_d;
            rout_q    <= rout_d;
            rin_q     <= rin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Mdatain  = mdatain_q;
    assign Read     = strb_q.read;
    assign MDRin    = strb_q.mdrin;
    assign MDRout   = strb_q.mdrout;
    assign Yin      = strb_q.yin;
    assign Zlowin   = strb_q.zlowin;
    assign ZHighin  = strb_q.zhighin;
    assign Zlowout  = strb_q.zlowout;
    assign Zhighout = strb_q.zhighout;
    assign HIin     = strb_q.hiin;
    assign LOin     = strb_q.loin;
    assign Rout     = rout_q;
    assign Rin      = rin_q;
    assign op       = op_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
